vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - Generates 640x480@60 VGA timing from the system clock and feeds col/row to the pixel drawer.
// - Samples the drawer's combinational RGB and registers it with hsync/vsync so colour and sync leave
//   the chip aligned.
// - Emits frame_start/vblank so game logic updates sprite positions outside active video.
// PARAMETERS
// CLK_DIV    2    clk cycles per pixel (1 => pix_en always high); 50 MHz/2 = 25 MHz
// H_ACTIVE   640  visible pixels per line
// H_FP       16   horizontal front porch, pixels
// H_SYNC     96   hsync width, pixels
// H_BP       48   horizontal back porch; H_TOTAL = sum = 800
// V_ACTIVE   480  visible lines
// V_FP       10   vertical front porch, lines
// V_SYNC     2    vsync width, lines
// V_BP       33   vertical back porch; V_TOTAL = sum = 525
// SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
// clk          in   1   system clock, all logic on rising edge
// reset_n      in   1   asynchronous, active-low reset
// red_in       in   4   drawer red for current col/row
// green_in     in   4   drawer green
// blue_in      in   4   drawer blue
// col          out  32  pixel column to drawer, 0..H_ACTIVE-1
// row          out  32  pixel row to drawer, 0..V_ACTIVE-1
// video_on     out  1   current h/v counter position is visible
// pix_en       out  1   one-clk pixel strobe
// frame_start  out  1   one-clk pulse at h=0,v=0
// vblank       out  1   high while v >= V_ACTIVE
// hsync        out  1   registered horizontal sync
// vsync        out  1   registered vertical sync
// red/green/blue out 4  registered VGA colour, blanked outside active video
// BEHAVIOUR
// - Interface: one clock, clk; reset_n asynchronous active-low, clears all state immediately mid-frame.
// - Reset values: div/h/v counters 0, col=row=0, video_on=0, pix_en=0, frame_start=0, vblank=0,
//   hsync=vsync=!SYNC_POL, red=green=blue=0.
// - Divider: div counts 0..CLK_DIV-1 and wraps; pix_en=1 while div==CLK_DIV-1.
//   First pix_en is on the CLK_DIV-th clk edge after reset release.
// - On pix_en: h increments; at h==H_TOTAL-1, h->0 and v increments; at v==V_TOTAL-1 with that wrap, v->0.
// - video_on = (h<H_ACTIVE)&&(v<V_ACTIVE), combinational from the counters.
// - col=h and row=v when video_on, else col=row=0, keeping drawer block indices in range.
// - vblank = (v>=V_ACTIVE).
// - frame_start=1 for exactly one clk: the cycle with pix_en=1, h==0, v==0.
// - Sync decode (pre-register):
//   hs_raw active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751 default).
//   vs_raw active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
// - Output stage, updated only on pix_en:
//   red/green/blue <= video_on ? *_in : 0;
//   hsync/vsync <= active ? SYNC_POL : !SYNC_POL.
// - Latency: RGB/sync outputs lag col/row/video_on by exactly one pixel, so colour and sync stay aligned.
// - Outputs hold between pix_en strobes; *_in is sampled only on pix_en, so the drawer may settle freely.
// - Counter arithmetic is unsigned 32-bit; no counter ever exceeds its TOTAL-1.
// CONFIGURATION
// - VGA_TEST_PATTERN_EN defined:
//   adds input test_mode (1 bit).
//   When test_mode=1, the output stage takes bar colour instead of *_in.
//   bar = col/(H_ACTIVE/8), 0..7; red=bar[2]?F:0, green=bar[1]?F:0, blue=bar[0]?F:0.
//   Blanking, sync and latency are unchanged.
// - VGA_TEST_PATTERN_EN undefined: no test_mode port; *_in always used.
// TESTING
// - Reset/divider: hold reset_n=0 5 clk -> all outputs at reset values, hsync=vsync=1.
//   Release -> pix_en high on clk 2,4,6...
// - Line timing: run one line -> 800 pix_en per line; hsync low for exactly 96 pixels starting 657th
//   output pixel (h=656 plus 1 latency).
// - Frame timing: run 2 frames -> 525 lines; vsync low 2 lines (v=490,491).
//   frame_start pulses once per frame, 420000 pix_en apart; vblank high for v=480..524.
// - Blanking/alignment: drive red_in=A,green_in=5,blue_in=C constantly ->
//   outputs A/5/C for h=0..639 one pixel late; 0 at h=640..799 and v>=480; col=row=0 when blanked.
// - Async reset mid-frame: assert reset_n at h=300,v=200 between clk edges ->
//   outputs clear without waiting for clk; after release the frame restarts at h=0,v=0 with frame_start.
// - VGA_TEST_PATTERN_EN, test_mode=1: col 0..79 -> 000; 80..159 -> 00F; 560..639 -> FFF;
//   test_mode=0 -> *_in passes through.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - drawer/monitor signal bundle for vga_timing_gen (test_mode exists only with VGA_TEST_PATTERN_EN)
interface vga_timing_gen_if;
  logic [3:0]  red_in;
  logic [3:0]  green_in;
  logic [3:0]  blue_in;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode;
`endif
  logic [31:0] col;
  logic [31:0] row;
  logic        video_on;
  logic        pix_en;
  logic        frame_start;
  logic        vblank;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  modport master (
    input  red_in, green_in, blue_in,
`ifdef VGA_TEST_PATTERN_EN
    input  test_mode,
`endif
    output col, row, video_on, pix_en, frame_start, vblank,
    output hsync, vsync, red, green, blue
  );

  modport slave (
    output red_in, green_in, blue_in,
`ifdef VGA_TEST_PATTERN_EN
    output test_mode,
`endif
    input  col, row, video_on, pix_en, frame_start, vblank,
    input  hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing with registered colour/sync; optional colour bars via VGA_TEST_PATTERN_EN
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
`endif

  logic [31:0] div_q;
  logic [31:0] h_q;
  logic [31:0] v_q;
  logic        run_q;
  logic        pix_en;
  logic        video_on;
  logic        hs_raw;
  logic        vs_raw;
  logic [3:0]  red_src;
  logic [3:0]  green_src;
  logic [3:0]  blue_src;
  logic [3:0]  red_q;
  logic [3:0]  green_q;
  logic [3:0]  blue_q;
  logic        hsync_q;
  logic        vsync_q;

  // Pixel-clock divider: counts 0..CLK_DIV-1, strobe on the last count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                div_q <= '0;
    else if (div_q == CLK_DIV-1) div_q <= '0;
    else                         div_q <= div_q + 32'd1;
  end

  // Run flag keeps video_on low while in reset, even though h=v=0 there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Raster counters advance once per pixel strobe, wrapping line then frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_en) begin
      if (h_q == H_TOTAL-1) begin
        h_q <= '0;
        if (v_q == V_TOTAL-1) v_q <= '0;
        else                  v_q <= v_q + 32'd1;
      end else begin
        h_q <= h_q + 32'd1;
      end
    end
  end

  // Position decode: strobe, visibility and raw sync windows
  always_comb begin
    pix_en   = (div_q == CLK_DIV-1);
    video_on = run_q && (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    hs_raw   = (h_q >= HS_START) && (h_q < HS_END);
    vs_raw   = (v_q >= VS_START) && (v_q < VS_END);
  end

  // Colour source: drawer inputs, or colour bars across the visible width
  always_comb begin
    red_src   = vga.red_in;
    green_src = vga.green_in;
    blue_src  = vga.blue_in;
`ifdef VGA_TEST_PATTERN_EN
    if (vga.test_mode) begin
      red_src   = {4{vga.col >= 4*BAR_W}};
      green_src = {4{(vga.col % (4*BAR_W)) >= 2*BAR_W}};
      blue_src  = {4{(vga.col % (2*BAR_W)) >= BAR_W}};
    end
`endif
  end

  // Output stage: colour and sync registered together so they leave aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_q   <= 4'h0;
      green_q <= 4'h0;
      blue_q  <= 4'h0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else if (pix_en) begin
      red_q   <= video_on ? red_src   : 4'h0;
      green_q <= video_on ? green_src : 4'h0;
      blue_q  <= video_on ? blue_src  : 4'h0;
      hsync_q <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.video_on    = video_on;
  assign vga.col         = video_on ? h_q : 32'd0;
  assign vga.row         = video_on ? v_q : 32'd0;
  assign vga.vblank      = (v_q >= V_ACTIVE);
  assign vga.frame_start = pix_en && (h_q == 32'd0) && (v_q == 32'd0);
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.red         = red_q;
  assign vga.green       = green_q;
  assign vga.blue        = blue_q;

endmodule
